// File: rtl/csc_sched_pkg.sv
// csc_sched_pkg: FSM state encoding and parameter
// defaults shared by the CSC encode scheduler files.
package csc_sched_pkg;

  localparam int SRC_ADDR_WIDTH_DEF = 10;
  localparam int NUM_BANKS_DEF      = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5
  } sched_state_e;

endpackage

// File: rtl/csc_col_addr_gen.sv
// csc_col_addr_gen: column-major source address walker
// (row inner, col outer) over a per-vector base accumulator.
module csc_col_addr_gen
  import csc_sched_pkg::*;
#(
  parameter int AW = SRC_ADDR_WIDTH_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          job_start_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic          next_vec_i,
  input  logic [4:0]    height_i,
  input  logic [4:0]    width_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  logic [4:0]    row_q, row_d;
  logic [4:0]    col_q, col_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] hw;
  logic          row_end;

  assign hw      = AW'(height_i) * AW'(width_i);
  assign row_end = (row_q == height_i - 5'd1);
  assign last_o  = row_end && (col_q == width_i - 5'd1);
  assign addr_o  = addr_q;

  // addr_q tracks base + row*W + col incrementally
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    base_d = base_q;
    addr_d = addr_q;
    unique case (1'b1)
      job_start_i: begin
        row_d  = '0;
        col_d  = '0;
        base_d = '0;
        addr_d = '0;
      end
      load_i: begin
        row_d  = '0;
        col_d  = '0;
        addr_d = base_q;
      end
      step_i: begin
        if (row_end) begin
          row_d  = '0;
          col_d  = col_q + 5'd1;
          addr_d = base_q + AW'(col_q + 5'd1);
        end else begin
          row_d  = row_q + 5'd1;
          addr_d = addr_q + AW'(width_i);
        end
      end
      next_vec_i: base_d = base_q + hw;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q  <= '0;
      col_q  <= '0;
      base_q <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      base_q <= base_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/csc_encode_scheduler.sv
// csc_encode_scheduler: streams vector matrices from the source
// buffer into the CSC encoder, one iact bank per vector.
module csc_encode_scheduler
  import csc_sched_pkg::*;
#(
  parameter int SRC_ADDR_WIDTH = SRC_ADDR_WIDTH_DEF,
  parameter int NUM_BANKS      = NUM_BANKS_DEF,
  parameter int BANK_SEL_WIDTH = $clog2(NUM_BANKS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [4:0]                cfg_matrix_height,
  input  logic [4:0]                cfg_matrix_width,
  input  logic [3:0]                cfg_num_vectors,
  output logic                      src_rd_en,
  output logic [SRC_ADDR_WIDTH-1:0] src_rd_addr,
  input  logic signed [7:0]         src_rd_data,
  output logic                      enc_data_in_valid,
  output logic signed [7:0]         enc_data_in,
  output logic [4:0]                enc_matrix_height,
  output logic [4:0]                enc_matrix_width,
  output logic                      enc_clear_iact_SRAM,
  input  logic                      enc_one_vector_done,
  output logic [BANK_SEL_WIDTH-1:0] bank_sel,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_error
);

  sched_state_e state_q, state_d;

  logic [4:0]                h_q, w_q;
  logic [3:0]                n_q, vec_q;
  logic [BANK_SEL_WIDTH-1:0] bank_q;
  logic                      err_q;
  logic                      rd_q, vld_q;
  logic signed [7:0]         data_q;

  logic cfg_bad, go, last;
  logic st_clear, st_feed, st_next;

  assign cfg_bad = (cfg_matrix_height == 5'd0) ||
                   (cfg_matrix_width == 5'd0) ||
                   (cfg_num_vectors == 4'd0);
  assign go      = (state_q == ST_IDLE) && start;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = cfg_bad ? ST_FIN : ST_CLEAR;
      ST_CLEAR: state_d = ST_FEED;
      ST_FEED:  if (last) state_d = ST_DRAIN;
      ST_DRAIN: if (enc_one_vector_done) state_d = ST_NEXT;
      ST_NEXT:  state_d = (vec_q + 4'd1 < n_q) ? ST_CLEAR : ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    st_clear = 1'b0;
    st_feed  = 1'b0;
    st_next  = 1'b0;
    done     = 1'b0;
    busy     = (state_q != ST_IDLE);
    unique case (state_q)
      ST_CLEAR: st_clear = 1'b1;
      ST_FEED:  st_feed  = 1'b1;
      ST_NEXT:  st_next  = 1'b1;
      ST_FIN:   done     = 1'b1;
      default:  ;
    endcase
  end

  csc_col_addr_gen #(
    .AW(SRC_ADDR_WIDTH)
  ) u_addr (
    .clk_i      (clock),
    .rst_i      (reset),
    .job_start_i(go),
    .load_i     (st_clear),
    .step_i     (st_feed),
    .next_vec_i (st_next),
    .height_i   (h_q),
    .width_i    (w_q),
    .addr_o     (src_rd_addr),
    .last_o     (last)
  );

  // every job restarts at vector 0 / bank 0
  always_ff @(posedge clock) begin
    if (reset) begin
      h_q    <= '0;
      w_q    <= '0;
      n_q    <= '0;
      vec_q  <= '0;
      bank_q <= '0;
      err_q  <= 1'b0;
    end else if (go) begin
      h_q    <= cfg_matrix_height;
      w_q    <= cfg_matrix_width;
      n_q    <= cfg_num_vectors;
      vec_q  <= '0;
      bank_q <= '0;
      err_q  <= cfg_bad;
    end else if (st_next) begin
      vec_q  <= vec_q + 4'd1;
      bank_q <= (bank_q == BANK_SEL_WIDTH'(NUM_BANKS - 1)) ?
                '0 : bank_q + 1'b1;
    end
  end

  // rd_q marks the cycle src_rd_data is valid
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q   <= 1'b0;
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      rd_q  <= st_feed;
      vld_q <= rd_q;
      if (rd_q) data_q <= src_rd_data;
    end
  end

  assign src_rd_en           = st_feed;
  assign enc_clear_iact_SRAM = st_clear;
  assign enc_data_in_valid   = vld_q;
  assign enc_data_in         = data_q;
  assign enc_matrix_height   = h_q;
  assign enc_matrix_width    = w_q;
  assign bank_sel            = bank_q;
  assign cfg_error           = err_q;

endmodule

// File: tb/tb_csc_encode_scheduler.sv
// tb_csc_encode_scheduler: randomized jobs checked against a
// list-based model of the column-major read schedule.
module tb_csc_encode_scheduler;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [4:0]        cfg_matrix_height;
  logic [4:0]        cfg_matrix_width;
  logic [3:0]        cfg_num_vectors;
  logic              src_rd_en;
  logic [9:0]        src_rd_addr;
  logic signed [7:0] src_rd_data;
  logic              enc_data_in_valid;
  logic signed [7:0] enc_data_in;
  logic [4:0]        enc_matrix_height;
  logic [4:0]        enc_matrix_width;
  logic              enc_clear_iact_SRAM;
  logic              enc_one_vector_done;
  logic [1:0]        bank_sel;
  logic              busy;
  logic              done;
  logic              cfg_error;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [7:0] mem [1024];

  always #5 clock = ~clock;

  csc_encode_scheduler dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .cfg_matrix_height  (cfg_matrix_height),
    .cfg_matrix_width   (cfg_matrix_width),
    .cfg_num_vectors    (cfg_num_vectors),
    .src_rd_en          (src_rd_en),
    .src_rd_addr        (src_rd_addr),
    .src_rd_data        (src_rd_data),
    .enc_data_in_valid  (enc_data_in_valid),
    .enc_data_in        (enc_data_in),
    .enc_matrix_height  (enc_matrix_height),
    .enc_matrix_width   (enc_matrix_width),
    .enc_clear_iact_SRAM(enc_clear_iact_SRAM),
    .enc_one_vector_done(enc_one_vector_done),
    .bank_sel           (bank_sel),
    .busy               (busy),
    .done               (done),
    .cfg_error          (cfg_error)
  );

  task automatic run_job(input string tag, input int hi, input int wi,
                         input int ni, input bit noise);
    int   exp_addr[$];
    int   got_addr[$];
    int   got_rc[$];
    int   got_data[$];
    int   got_dc[$];
    int   banks[$];
    int   reads_v, encs_v, dly, done_cnt, done_cyc, hs_cyc, busy_low;
    int   pend_a, nshow;
    bit   pend, bad;
    logic err;
    bad = (hi == 0) || (wi == 0) || (ni == 0);
    for (int v = 0; v < ni; v++)
      for (int c = 0; c < wi; c++)
        for (int r = 0; r < hi; r++)
          exp_addr.push_back((v * hi * wi + r * wi + c) % 1024);
    cfg_matrix_height   = 5'(hi);
    cfg_matrix_width    = 5'(wi);
    cfg_num_vectors     = 4'(ni);
    start               = 1'b1;
    enc_one_vector_done = 1'b0;
    pend = 1'b0; pend_a = 0; reads_v = 0; encs_v = 0; dly = -1;
    done_cnt = 0; done_cyc = -1; hs_cyc = -1; busy_low = 0; err = 1'b0;
    for (int k = 1; k < 6000; k++) begin
      @(negedge clock);
      start = 1'b0;
      enc_one_vector_done = 1'b0;
      if (src_rd_en) begin
        got_addr.push_back(int'(src_rd_addr));
        got_rc.push_back(k);
        reads_v++;
      end
      if (enc_data_in_valid) begin
        got_data.push_back(int'(enc_data_in));
        got_dc.push_back(k);
        encs_v++;
      end
      if (enc_clear_iact_SRAM) begin
        banks.push_back(int'(bank_sel));
        n_tests++;
        if (enc_matrix_height !== 5'(hi) || enc_matrix_width !== 5'(wi)) begin
          n_fail++;
          $display("FAIL %s clear_dims: got %0dx%0d, expected %0dx%0d", tag,
                   enc_matrix_height, enc_matrix_width, hi, wi);
        end
      end
      if (!busy && done_cyc < 0) busy_low++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k;
          err = cfg_error;
        end
      end
      src_rd_data = pend ? mem[pend_a] : 8'($urandom);
      pend   = src_rd_en;
      pend_a = int'(src_rd_addr);
      if (noise && src_rd_en && reads_v == 1 && hi * wi >= 3) begin
        cfg_matrix_height   = 5'(hi + 1);
        start               = 1'b1;
        enc_one_vector_done = 1'b1;
      end
      if (!bad && encs_v == hi * wi) begin
        encs_v  = 0;
        reads_v = 0;
        dly     = int'($urandom_range(0, 3));
      end
      if (dly == 0) begin
        enc_one_vector_done = 1'b1;
        hs_cyc = k;
        dly    = -1;
      end else if (dly > 0) begin
        dly--;
      end
      if (done_cyc >= 0 && k >= done_cyc + 3) break;
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d, expected 1", tag, done_cnt);
    end
    n_tests++;
    if (busy_low != 0) begin
      n_fail++;
      $display("FAIL %s busy_gap: got %0d idle cycles, expected 0", tag, busy_low);
    end
    n_tests++;
    if (err !== bad) begin
      n_fail++;
      $display("FAIL %s cfg_error: got %b, expected %b", tag, err, bad);
    end
    n_tests++;
    if (got_addr.size() != exp_addr.size()) begin
      n_fail++;
      $display("FAIL %s read_count: got %0d, expected %0d", tag,
               got_addr.size(), exp_addr.size());
    end
    if (bad) begin
      n_tests++;
      if (done_cyc < 1 || done_cyc > 2) begin
        n_fail++;
        $display("FAIL %s bad_done_latency: got %0d, expected 1..2", tag, done_cyc);
      end
      n_tests++;
      if (cfg_error !== 1'b1) begin
        n_fail++;
        $display("FAIL %s cfg_error_hold: got %b, expected 1", tag, cfg_error);
      end
      return;
    end
    nshow = 0;
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_tests++;
      if (got_addr[i] != exp_addr[i]) begin
        n_fail++;
        if (nshow++ < 4)
          $display("FAIL %s rd_addr[%0d]: got %0d, expected %0d", tag, i,
                   got_addr[i], exp_addr[i]);
      end
    end
    n_tests++;
    if (got_data.size() != exp_addr.size()) begin
      n_fail++;
      $display("FAIL %s enc_count: got %0d, expected %0d", tag,
               got_data.size(), exp_addr.size());
    end
    nshow = 0;
    for (int i = 0; i < exp_addr.size() && i < got_data.size(); i++) begin
      n_tests++;
      if (got_data[i] != int'(mem[exp_addr[i]]) ||
          (i < got_rc.size() && got_dc[i] != got_rc[i] + 2)) begin
        n_fail++;
        if (nshow++ < 4)
          $display("FAIL %s enc_data[%0d]: got %0d at cyc %0d, expected %0d",
                   tag, i, got_data[i], got_dc[i], mem[exp_addr[i]]);
      end
    end
    n_tests++;
    if (banks.size() != ni) begin
      n_fail++;
      $display("FAIL %s clear_count: got %0d, expected %0d", tag, banks.size(), ni);
    end
    for (int i = 0; i < banks.size(); i++) begin
      n_tests++;
      if (banks[i] != i % 4) begin
        n_fail++;
        $display("FAIL %s bank_sel[%0d]: got %0d, expected %0d", tag, i,
                 banks[i], i % 4);
      end
    end
    n_tests++;
    if (done_cyc != hs_cyc + 2) begin
      n_fail++;
      $display("FAIL %s done_timing: got cyc %0d, expected %0d", tag,
               done_cyc, hs_cyc + 2);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_tests++;
    if ({src_rd_en, enc_data_in_valid, enc_data_in, enc_clear_iact_SRAM,
         bank_sel, busy, done, cfg_error, enc_matrix_height,
         enc_matrix_width} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {src_rd_en, enc_data_in_valid, enc_data_in, enc_clear_iact_SRAM,
                bank_sel, busy, done, cfg_error, enc_matrix_height,
                enc_matrix_width});
    end
    n_tests++;
    if (src_rd_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %0d, expected 0", src_rd_addr);
    end
    reset = 1'b0;
    @(negedge clock);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < 6; i++) mem[i] = 8'(i);
    run_job("basic_3x2x1", 3, 2, 1, 1'b0);
  endtask

  task automatic test_banks;
    run_job("banks_2x2x5", 2, 2, 5, 1'b0);
  endtask

  task automatic test_bad_cfg;
    run_job("bad_w0", 4, 0, 2, 1'b0);
    run_job("bad_h0", 0, 3, 1, 1'b0);
    run_job("bad_n0", 2, 2, 0, 1'b0);
    run_job("good_after_bad", 1, 1, 1, 1'b0);
  endtask

  task automatic test_ignore;
    run_job("ignore_3x3x2", 3, 3, 2, 1'b1);
  endtask

  task automatic test_reset_mid_job;
    int reads, dcount;
    cfg_matrix_height = 5'd2;
    cfg_matrix_width  = 5'd3;
    cfg_num_vectors   = 4'd2;
    start = 1'b1;
    reads = 0;
    for (int k = 0; k < 40 && reads < 6; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (src_rd_en) reads++;
    end
    @(negedge clock);
    n_tests++;
    if (busy !== 1'b1 || src_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_entry: got busy=%b rd=%b, expected 1 0", busy, src_rd_en);
    end
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if ({src_rd_en, enc_data_in_valid, enc_data_in, enc_clear_iact_SRAM,
         bank_sel, busy, done, cfg_error, enc_matrix_height,
         enc_matrix_width} !== 26'd0) begin
      n_fail++;
      $display("FAIL midjob_reset_outputs: got %b, expected all zero",
               {src_rd_en, enc_data_in_valid, enc_data_in, enc_clear_iact_SRAM,
                bank_sel, busy, done, cfg_error, enc_matrix_height,
                enc_matrix_width});
    end
    reset = 1'b0;
    dcount = 0;
    repeat (4) begin
      @(negedge clock);
      if (done) dcount++;
    end
    n_tests++;
    if (dcount != 0) begin
      n_fail++;
      $display("FAIL midjob_no_done: got %0d pulses, expected 0", dcount);
    end
    run_job("after_reset_2x2x2", 2, 2, 2, 1'b0);
  endtask

  task automatic test_random;
    for (int j = 0; j < 6; j++)
      run_job("random", int'($urandom_range(1, 7)), int'($urandom_range(1, 7)),
              int'($urandom_range(1, 6)), 1'($urandom));
  endtask

  task automatic test_max;
    run_job("max_31x31x2", 31, 31, 2, 1'b0);
  endtask

  initial begin
    reset               = 1'b1;
    start               = 1'b0;
    cfg_matrix_height   = '0;
    cfg_matrix_width    = '0;
    cfg_num_vectors     = '0;
    enc_one_vector_done = 1'b0;
    src_rd_data         = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    test_reset;
    test_basic;
    test_banks;
    test_bad_cfg;
    test_ignore;
    test_reset_mid_job;
    test_random;
    test_max;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csc_encode_scheduler.md
CSC_ENCODE_SCHEDULER -- requirements
Module: csc_encode_scheduler

Interface
REQ-001 The block SHALL have parameter SRC_ADDR_WIDTH, default 10, giving the source activation buffer address width.
REQ-002 The block SHALL have parameter NUM_BANKS, default 4, giving the number of iact SRAM banks served round-robin.
REQ-003 The block SHALL have parameter BANK_SEL_WIDTH, default 2, equal to clog2(NUM_BANKS).
REQ-004 The block SHALL use one clock with synchronous, active-high reset, on ports clock and reset.
REQ-005 The block SHALL have the following ports (name, direction, width, meaning):
- clock, input, 1: the single clock.
- reset, input, 1: synchronous active-high reset.
- start, input, 1: one-cycle job start.
- cfg_matrix_height, input, 5: rows per vector matrix.
- cfg_matrix_width, input, 5: columns per vector matrix.
- cfg_num_vectors, input, 4: vectors per job.
- src_rd_en, output, 1: source buffer read strobe.
- src_rd_addr, output, SRC_ADDR_WIDTH: source read address.
- src_rd_data, input, 8 signed: read data, valid 1 cycle after src_rd_en.
- enc_data_in_valid, output, 1: element valid to the CSC encoder.
- enc_data_in, output, 8 signed: element to the CSC encoder.
- enc_matrix_height, output, 5: latched height.
- enc_matrix_width, output, 5: latched width.
- enc_clear_iact_SRAM, output, 1: bank clear request.
- enc_one_vector_done, input, 1: encoder vector terminator.
- bank_sel, output, BANK_SEL_WIDTH: destination bank.
- busy, output, 1: job in progress.
- done, output, 1: one-cycle job-complete pulse.
- cfg_error, output, 1: illegal configuration flag.

Function
REQ-006 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN, NEXT, FIN.
REQ-007 In IDLE, start SHALL latch cfg_* and go to CLEAR; start in any other state SHALL be ignored.
REQ-008 At start, if height, width or num_vectors is 0, the FSM SHALL go to FIN with cfg_error=1 and issue no reads; cfg_error SHALL stay set until the next start.
REQ-009 CLEAR SHALL last exactly 1 cycle with enc_clear_iact_SRAM=1, then go to FEED.
REQ-010 FEED SHALL issue exactly H*W reads, one per cycle, in column-major order: col outer, row inner, src_rd_addr = vec*H*W + row*W + col, computed in 10 bits with wrap-around.
REQ-011 enc_data_in_valid/enc_data_in SHALL be src_rd_en/src_rd_data delayed by one register stage (read-to-encoder latency 2 cycles).
REQ-012 After the last read the FSM SHALL go to DRAIN; the final pipelined element SHALL still be delivered.
REQ-013 DRAIN SHALL wait for enc_one_vector_done, then go to NEXT; a done pulse in any other state SHALL be ignored.
REQ-014 NEXT SHALL last 1 cycle: vec increments, bank_sel = (bank_sel+1) mod NUM_BANKS, then CLEAR if vec < num_vectors, else FIN.
REQ-015 FIN SHALL last 1 cycle with done=1, then return to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 enc_matrix_height and enc_matrix_width SHALL remain stable from CLEAR through DRAIN of the job.

Reset
REQ-018 Reset SHALL force IDLE, with src_rd_en=0, enc_data_in_valid=0, enc_data_in=0, enc_clear_iact_SRAM=0, bank_sel=0, busy=0, done=0, cfg_error=0, enc_matrix_height=0, enc_matrix_width=0, and row/col/vec counters at 0.
REQ-019 Reset mid-job SHALL abort immediately with no done pulse; the next start SHALL begin again at bank 0.

Structure
REQ-020 The FSM state encoding and the NUM_BANKS/SRC_ADDR_WIDTH defaults SHALL live in a shared package csc_sched_pkg.
REQ-021 The column-major address generation (row/col counters and base accumulator) SHALL be one sub-module, csc_col_addr_gen.

Verification
REQ-022 H=3, W=2, N=1, source = 0..5 row-major -> reads at addr 0,2,4,1,3,5; enc_data_in sequence 0,2,4,1,3,5; 1 clear; done 1 cycle after DRAIN exits.
REQ-023 H=2, W=2, N=5 -> bank_sel sequence 0,1,2,3,0; 5 clear pulses; vector 4 base address = 16.
REQ-024 cfg_matrix_width=0 with start -> no src_rd_en, cfg_error=1, done pulses within 2 cycles.
REQ-025 start pulsed again during FEED and a spurious enc_one_vector_done in FEED -> both ignored; read count stays H*W.
REQ-026 reset asserted in DRAIN -> all outputs at reset values the next cycle, no done; a new job then starts at bank_sel=0.
REQ-027 H=W=31, N=2 -> 961 reads per vector; vector 1 base address = 961 mod 1024 = 961; last vector read addresses wrap modulo 1024.
